// File: rtl/route_pkg.sv
// ---------------------------------------------------------------------------
// route_pkg
// Shared definitions for the routing crossbar:
//   cfgState_e - states of the serial configuration loader
//   calcNbits  - configuration word length for a V x H crossbar
//                (one cross bit per cell plus one output enable per column)
// ---------------------------------------------------------------------------
package route_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    FULL = 2'd2
  } cfgState_e;

  function automatic int calcNbits(input int v, input int h);
    return v * h + v;
  endfunction

endpackage

// File: rtl/route_cell.sv
// ---------------------------------------------------------------------------
// route_cell
// One crosspoint of the routing crossbar.
// Ports:
//   prog_i - cross bit; 1 joins the two channels, 0 passes them straight
//   n_i    - vertical signal arriving from the north
//   w_i    - horizontal signal arriving from the west
//   s_o    - vertical signal leaving to the south
//   e_o    - horizontal signal leaving to the east
// ---------------------------------------------------------------------------
module route_cell (
  input  logic prog_i,
  input  logic n_i,
  input  logic w_i,
  output logic s_o,
  output logic e_o
);

  logic joined;

  // A programmed cell merges both channels, so east and south both carry
  // the OR of north and west; an unprogrammed cell passes each straight on.
  always_comb begin
    joined = n_i | w_i;
    s_o    = prog_i ? joined : n_i;
    e_o    = prog_i ? joined : w_i;
  end

endmodule

// File: rtl/route_xbar.sv
// ---------------------------------------------------------------------------
// route_xbar
// V x H routing crossbar with a serially loaded, double-buffered
// configuration. Bits are shifted into a shadow register. A commit copies
// the full shadow into the active register that drives the data path, so
// live routing never sees a partial load.
// Ports:
//   clk, rst_n        - clock, asynchronous active-low reset
//   cfg_din/cfg_valid - serial configuration bit and its valid strobe
//   cfg_ready         - a bit is accepted this cycle (low once full)
//   cfg_commit        - copy shadow to active (only legal when full)
//   cfg_abort         - discard the current load
//   cfg_full          - shadow holds a complete new configuration
//   cfg_err           - one-cycle pulse after an illegal commit
//   V_i/V_o           - vertical channels in (north) / out (south, gated)
//   H_i/H_o           - horizontal channels in (west) / out (east)
// Config word layout (first bit sent lands in the MSB): row x of the cross
// field starts at bit NBITS-1-V*x, with column 0 at that start bit and
// column y at NBITS-1-V*x-y. The low V bits are the south output enables.
// PIPE=1 adds one register stage on H_o/V_o.
// ---------------------------------------------------------------------------
module route_xbar
  import route_pkg::*;
#(
  parameter int V    = 4,
  parameter int H    = 4,
  parameter int PIPE = 0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         cfg_din,
  input  logic         cfg_valid,
  output logic         cfg_ready,
  input  logic         cfg_commit,
  input  logic         cfg_abort,
  output logic         cfg_full,
  output logic         cfg_err,
  input  logic [V-1:0] V_i,
  output logic [V-1:0] V_o,
  input  logic [H-1:0] H_i,
  output logic [H-1:0] H_o
);

  localparam int NBITS = calcNbits(V, H);
  localparam int CW    = $clog2(NBITS + 1);

  cfgState_e        state_q, state_d;
  logic [CW-1:0]    count_q, count_d;
  logic [NBITS-1:0] shadow_q, shadow_d;
  logic [NBITS-1:0] activeCfg_q, activeCfg_d;
  logic             err_q, err_d;
  logic             xfer;

  logic [H-1:0]     hRaw;
  logic [V-1:0]     vRaw;

  assign cfg_ready = (state_q != FULL);
  assign cfg_full  = (state_q == FULL);
  assign cfg_err   = err_q;
  assign xfer      = cfg_valid && cfg_ready;

  // Configuration state register. Reset clears everything, including the
  // active config, so an interrupted load can never leak into routing.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      count_q     <= '0;
      shadow_q    <= '0;
      activeCfg_q <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      shadow_q    <= shadow_d;
      activeCfg_q <= activeCfg_d;
      err_q       <= err_d;
    end
  end

  // Loader next-state logic. Abort overrides everything else in the cycle.
  // A commit outside FULL is dropped and flagged; in IDLE/LOAD it can
  // coincide with a transfer, which still proceeds. In FULL, ready is low,
  // so a commit never collides with a shift.
  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    shadow_d    = shadow_q;
    activeCfg_d = activeCfg_q;
    err_d       = 1'b0;

    if (cfg_abort) begin
      state_d = IDLE;
      count_d = '0;
    end else begin
      if (cfg_commit) begin
        if (state_q == FULL) begin
          activeCfg_d = shadow_q;
          count_d     = '0;
          state_d     = IDLE;
        end else begin
          err_d = 1'b1;
        end
      end
      if (xfer) begin
        shadow_d = {shadow_q[NBITS-2:0], cfg_din};
        count_d  = count_q + 1'b1;
        state_d  = (count_q == CW'(NBITS - 1)) ? FULL : LOAD;
      end
    end
  end

  // Cross-cell grid: horizontal chains run along rows from H_i[x], vertical
  // chains run down columns from V_i[y]. Each cell keeps its own wires so
  // the chains form no self-referencing vector.
  for (genvar x = 0; x < H; x++) begin : gRow
    for (genvar y = 0; y < V; y++) begin : gCol
      logic north, west, south, east;

      if (x == 0) begin : gTop
        assign north = V_i[y];
      end else begin : gInner
        assign north = gRow[x-1].gCol[y].south;
      end

      if (y == 0) begin : gLeft
        assign west = H_i[x];
      end else begin : gMid
        assign west = gCol[y-1].east;
      end

      route_cell uCell (
        .prog_i (activeCfg_q[NBITS-1-V*x-y]),
        .n_i    (north),
        .w_i    (west),
        .s_o    (south),
        .e_o    (east)
      );
    end

    assign hRaw[x] = gCol[V-1].east;
  end

  // South outputs are gated by the per-column enables held in the low bits.
  for (genvar y = 0; y < V; y++) begin : gYen
    assign vRaw[y] = gRow[H-1].gCol[y].south & activeCfg_q[y];
  end

  if (PIPE != 0) begin : gPipe
    logic [H-1:0] hOut_q;
    logic [V-1:0] vOut_q;

    // Optional output stage: one cycle of latency on both data outputs.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        hOut_q <= '0;
        vOut_q <= '0;
      end else begin
        hOut_q <= hRaw;
        vOut_q <= vRaw;
      end
    end

    assign H_o = hOut_q;
    assign V_o = vOut_q;
  end else begin : gComb
    assign H_o = hRaw;
    assign V_o = vRaw;
  end

endmodule

// File: tb/tb_route_xbar.sv
// ---------------------------------------------------------------------------
// tb_route_xbar
// Drives a 2x2 combinational crossbar and a 2x2 pipelined crossbar from the
// same stimulus and checks both against hand-computed expectations.
// ---------------------------------------------------------------------------
module tb_route_xbar;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cfg_din, cfg_valid, cfg_commit, cfg_abort;
  logic [1:0] H_i, V_i;

  logic       cfgReady, cfgFull, cfgErr;
  logic [1:0] hOut, vOut;
  logic       readyP, fullP, errP;
  logic [1:0] hOutP, vOutP;

  int checks   = 0;
  int failures = 0;

  typedef struct packed {
    logic [1:0] hIn;
    logic [1:0] vIn;
    logic [1:0] hExp;
    logic [1:0] vExp;
  } vec_t;

  vec_t tabA [7];
  vec_t tabB [5];

  always #5 clk = ~clk;

  route_xbar #(.V(2), .H(2), .PIPE(0)) dut (
    .clk(clk), .rst_n(rst_n), .cfg_din(cfg_din), .cfg_valid(cfg_valid),
    .cfg_ready(cfgReady), .cfg_commit(cfg_commit), .cfg_abort(cfg_abort),
    .cfg_full(cfgFull), .cfg_err(cfgErr),
    .V_i(V_i), .V_o(vOut), .H_i(H_i), .H_o(hOut)
  );

  route_xbar #(.V(2), .H(2), .PIPE(1)) dutP (
    .clk(clk), .rst_n(rst_n), .cfg_din(cfg_din), .cfg_valid(cfg_valid),
    .cfg_ready(readyP), .cfg_commit(cfg_commit), .cfg_abort(cfg_abort),
    .cfg_full(fullP), .cfg_err(errP),
    .V_i(V_i), .V_o(vOutP), .H_i(H_i), .H_o(hOutP)
  );

  task automatic checkOutput(input string name, input logic [7:0] act,
                             input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input logic [1:0] hIn, input logic [1:0] vIn);
    H_i = hIn;
    V_i = vIn;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic shiftBits(input logic [7:0] bits, input int n);
    logic [7:0] b;
    b = bits;
    for (int i = n - 1; i >= 0; i--) begin
      cfg_din   = b[i];
      cfg_valid = 1'b1;
      tick();
    end
    cfg_valid = 1'b0;
    cfg_din   = 1'b0;
  endtask

  task automatic pulseCommit();
    cfg_commit = 1'b1;
    tick();
    cfg_commit = 1'b0;
  endtask

  task automatic pulseAbort();
    cfg_abort = 1'b1;
    tick();
    cfg_abort = 1'b0;
  endtask

  task automatic runVec(input string tag, input vec_t v);
    applyStimulus(v.hIn, v.vIn);
    checkOutput({tag, " H_o"}, 8'(hOut), 8'(v.hExp));
    checkOutput({tag, " V_o"}, 8'(vOut), 8'(v.vExp));
    tick();
    checkOutput({tag, " pipe H_o"}, 8'(hOutP), 8'(v.hExp));
    checkOutput({tag, " pipe V_o"}, 8'(vOutP), 8'(v.vExp));
  endtask

  initial begin
    // Config A = 6'b100011: cell(0,0) set, both south enables on.
    // H_o = {H1, V0|H0}, V_o = {V1, V0|H0}
    tabA[0] = '{2'b01, 2'b00, 2'b01, 2'b01};
    tabA[1] = '{2'b00, 2'b00, 2'b00, 2'b00};
    tabA[2] = '{2'b10, 2'b00, 2'b10, 2'b00};
    tabA[3] = '{2'b00, 2'b01, 2'b01, 2'b01};
    tabA[4] = '{2'b00, 2'b10, 2'b00, 2'b10};
    tabA[5] = '{2'b11, 2'b11, 2'b11, 2'b11};
    tabA[6] = '{2'b10, 2'b01, 2'b11, 2'b01};
    // Config B = 6'b010110: cells (0,1),(1,1) set, only column 1 enabled.
    // H_o = {V1|H0|H1, V1|H0}, V_o = {V1|H0|H1, 0}
    tabB[0] = '{2'b00, 2'b00, 2'b00, 2'b00};
    tabB[1] = '{2'b01, 2'b00, 2'b11, 2'b10};
    tabB[2] = '{2'b10, 2'b00, 2'b10, 2'b10};
    tabB[3] = '{2'b00, 2'b01, 2'b00, 2'b00};
    tabB[4] = '{2'b00, 2'b10, 2'b11, 2'b10};

    rst_n      = 1'b0;
    cfg_din    = 1'b0;
    cfg_valid  = 1'b0;
    cfg_commit = 1'b0;
    cfg_abort  = 1'b0;

    // Reset state
    applyStimulus(2'b11, 2'b11);
    checkOutput("reset H_o", 8'(hOut), 8'h3);
    checkOutput("reset V_o", 8'(vOut), 8'h0);
    checkOutput("reset ready", 8'(cfgReady), 8'h1);
    checkOutput("reset full", 8'(cfgFull), 8'h0);
    checkOutput("reset err", 8'(cfgErr), 8'h0);
    checkOutput("reset pipe H_o", 8'(hOutP), 8'h0);
    checkOutput("reset pipe V_o", 8'(vOutP), 8'h0);
    #10;
    rst_n = 1'b1;
    tick();
    checkOutput("post reset pipe H_o", 8'(hOutP), 8'h3);

    // Pipelined path follows H_i one cycle later
    applyStimulus(2'b10, 2'b00);
    checkOutput("toggle H_o", 8'(hOut), 8'h2);
    checkOutput("toggle pipe H_o old", 8'(hOutP), 8'h3);
    tick();
    checkOutput("toggle pipe H_o new", 8'(hOutP), 8'h2);

    // Load config A; routing must not change while loading
    applyStimulus(2'b01, 2'b00);
    tick();
    shiftBits(8'b100011, 6);
    checkOutput("A full", 8'(cfgFull), 8'h1);
    checkOutput("A ready", 8'(cfgReady), 8'h0);
    checkOutput("A pipe full", 8'(fullP), 8'h1);
    checkOutput("A pre-commit V_o", 8'(vOut), 8'h0);
    pulseCommit();
    checkOutput("A commit V_o", 8'(vOut), 8'h1);
    checkOutput("A commit pipe V_o", 8'(vOutP), 8'h0);
    checkOutput("A commit full", 8'(cfgFull), 8'h0);
    checkOutput("A commit ready", 8'(cfgReady), 8'h1);
    tick();
    checkOutput("A commit+2 pipe V_o", 8'(vOutP), 8'h1);
    for (int i = 0; i < 7; i++) runVec($sformatf("tabA[%0d]", i), tabA[i]);

    // Illegal commit during a partial load
    applyStimulus(2'b01, 2'b00);
    shiftBits(8'b111, 3);
    pulseCommit();
    checkOutput("bad commit err", 8'(cfgErr), 8'h1);
    checkOutput("bad commit pipe err", 8'(errP), 8'h1);
    checkOutput("bad commit ready", 8'(cfgReady), 8'h1);
    checkOutput("bad commit V_o", 8'(vOut), 8'h1);
    tick();
    checkOutput("bad commit err clear", 8'(cfgErr), 8'h0);
    pulseAbort();

    // Full shadow ignores further bits; abort leaves routing alone
    shiftBits(8'b010110, 6);
    checkOutput("B full", 8'(cfgFull), 8'h1);
    shiftBits(8'b11, 2);
    checkOutput("B still full", 8'(cfgFull), 8'h1);
    checkOutput("B ready low", 8'(readyP), 8'h0);
    pulseAbort();
    checkOutput("abort full", 8'(cfgFull), 8'h0);
    checkOutput("abort ready", 8'(cfgReady), 8'h1);
    checkOutput("abort H_o", 8'(hOut), 8'h1);
    checkOutput("abort V_o", 8'(vOut), 8'h1);

    // Reload B, extra bits must not shift the full shadow
    shiftBits(8'b010110, 6);
    shiftBits(8'b11, 2);
    pulseCommit();
    checkOutput("B commit err", 8'(cfgErr), 8'h0);
    for (int i = 0; i < 5; i++) runVec($sformatf("tabB[%0d]", i), tabB[i]);

    // Abort wins over a same-cycle commit
    shiftBits(8'b100011, 6);
    cfg_abort  = 1'b1;
    cfg_commit = 1'b1;
    tick();
    cfg_abort  = 1'b0;
    cfg_commit = 1'b0;
    checkOutput("abort+commit err", 8'(cfgErr), 8'h0);
    checkOutput("abort+commit full", 8'(cfgFull), 8'h0);
    applyStimulus(2'b01, 2'b00);
    checkOutput("abort+commit H_o", 8'(hOut), 8'h3);
    checkOutput("abort+commit V_o", 8'(vOut), 8'h2);

    // Asynchronous reset in the middle of a load
    applyStimulus(2'b00, 2'b10);
    checkOutput("pre-reset V_o", 8'(vOut), 8'h2);
    shiftBits(8'b101, 3);
    #3;
    rst_n = 1'b0;
    #1;
    checkOutput("async reset V_o", 8'(vOut), 8'h0);
    checkOutput("async reset H_o", 8'(hOut), 8'h0);
    checkOutput("async reset pipe H_o", 8'(hOutP), 8'h0);
    checkOutput("async reset pipe V_o", 8'(vOutP), 8'h0);
    checkOutput("async reset ready", 8'(cfgReady), 8'h1);
    #2;
    rst_n = 1'b1;
    tick();
    // Counter restarted from zero: full only after six fresh bits
    shiftBits(8'b10001, 5);
    checkOutput("post reset 5 bits full", 8'(cfgFull), 8'h0);
    shiftBits(8'b1, 1);
    checkOutput("post reset 6 bits full", 8'(cfgFull), 8'h1);
    pulseCommit();
    runVec("post reset A", tabA[0]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
